wired_branch_resolve: RTL and testbench

- Execute-stage stage directly downstream of the branch compare/target unit.
- Registers its taken decision and target and compares them with the frontend prediction carried by the instruction.
- Emits a one-cycle frontend redirect on mispredict, buffers predictor updates in a small FIFO, and hands a writeback record (link value, mispredict flag) to the ROB over valid/ready.
- Drops wrong-path branches in the shadow of a mispredict until the backend flush arrives.

---
 rtl/wired_branch_resolve.sv | 175 +++++++++++++++++
 tb/tb_wired_branch_resolve.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/wired_branch_resolve.sv
// wired_branch_resolve: execute-stage branch resolution.
// Registers the resolved branch, compares it against the frontend prediction,
// emits a one-cycle redirect on mispredict, queues predictor updates in a small
// FIFO and hands a writeback record to the ROB. Wrong-path branches arriving
// after a mispredict are dropped until the backend flush.
// Optional macro WIRED_BR_PERF_EN adds branch / mispredict counters.
module wired_branch_resolve #(
  parameter int ROB_W     = 6,
  parameter int UPD_DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [31:0]      pc_i,
  input  logic [ROB_W-1:0] rob_id_i,
  input  logic [1:0]       target_type_i,
  input  logic             taken_i,
  input  logic [31:0]      target_i,
  input  logic             pred_taken_i,
  input  logic [31:0]      pred_target_i,
  input  logic             flush_i,
  output logic             redir_valid_o,
  output logic [31:0]      redir_pc_o,
  output logic             wb_valid_o,
  input  logic             wb_ready_i,
  output logic [ROB_W-1:0] wb_rob_id_o,
  output logic [31:0]      wb_link_o,
  output logic             wb_link_we_o,
  output logic             wb_mispred_o,
  output logic             upd_valid_o,
  input  logic             upd_ready_i,
  output logic [31:0]      upd_pc_o,
  output logic             upd_taken_o,
  output logic [31:0]      upd_target_o,
  output logic [1:0]       upd_type_o
`ifdef WIRED_BR_PERF_EN
  ,
  output logic [31:0]      perf_branch_o,
  output logic [31:0]      perf_mispred_o
`endif
);

  localparam int PW = (UPD_DEPTH > 1) ? $clog2(UPD_DEPTH) : 1;
  localparam int CW = PW + 1;

  typedef enum logic {RUN = 1'b0, SHADOW = 1'b1} state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic        taken;
    logic [31:0] target;
    logic [1:0]  typ;
  } upd_t;

  state_e           state_q, state_d;
  upd_t             mem_q [UPD_DEPTH];
  logic [PW-1:0]    wr_q, rd_q;
  logic [CW-1:0]    cnt_q;
  logic             redir_valid_q;
  logic [31:0]      redir_pc_q;
  logic             wb_valid_q, wb_link_we_q, wb_mispred_q;
  logic [ROB_W-1:0] wb_rob_id_q;
  logic [31:0]      wb_link_q;

  logic        full, pop, push, acc, not_full, mispred;
  logic [31:0] link_pc, next_pc;

  assign link_pc = pc_i + 32'd4;
  assign next_pc = taken_i ? target_i : link_pc;
  assign mispred = (taken_i != pred_taken_i) | (taken_i & (target_i != pred_target_i));

  assign full        = (cnt_q == CW'(UPD_DEPTH));
  assign upd_valid_o = (cnt_q != '0);
  assign pop         = upd_valid_o & upd_ready_i;
  // A full FIFO still has room this cycle if its head is leaving.
  assign not_full    = !full | upd_ready_i;

  assign in_ready_o = !flush_i & ((state_q == SHADOW) | ((!wb_valid_q | wb_ready_i) & not_full));
  assign acc        = in_valid_i & in_ready_o;
  assign push       = acc & (state_q == RUN);

  // Next-state: flush always returns to RUN; a mispredict in RUN opens the shadow.
  always_comb begin
    state_d = state_q;
    if (flush_i)             state_d = RUN;
    else if (push & mispred) state_d = SHADOW;
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= RUN;
    else        state_q <= state_d;
  end

  // Redirect pulse; registered, so a later flush cannot cancel it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      redir_valid_q <= 1'b0;
      redir_pc_q    <= '0;
    end else begin
      redir_valid_q <= push & mispred;
      if (push & mispred) redir_pc_q <= next_pc;
    end
  end

  // Writeback register: flush clears, accept loads, ROB ready unloads.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_valid_q   <= 1'b0;
      wb_rob_id_q  <= '0;
      wb_link_q    <= '0;
      wb_link_we_q <= 1'b0;
      wb_mispred_q <= 1'b0;
    end else if (flush_i) begin
      wb_valid_q <= 1'b0;
    end else if (push) begin
      wb_valid_q   <= 1'b1;
      wb_rob_id_q  <= rob_id_i;
      wb_link_q    <= link_pc;
      wb_link_we_q <= (target_type_i == 2'd1);
      wb_mispred_q <= mispred;
    end else if (wb_ready_i) begin
      wb_valid_q <= 1'b0;
    end
  end

  // Predictor update FIFO; flush leaves it alone so resolved updates drain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < UPD_DEPTH; i++) mem_q[i] <= '0;
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push) begin
        mem_q[wr_q] <= '{pc: pc_i, taken: taken_i, target: target_i, typ: target_type_i};
        wr_q        <= wr_q + 1'b1;
      end
      if (pop) rd_q <= rd_q + 1'b1;
      cnt_q <= cnt_q + CW'(push) - CW'(pop);
    end
  end

  assign redir_valid_o = redir_valid_q;
  assign redir_pc_o    = redir_pc_q;
  assign wb_valid_o    = wb_valid_q;
  assign wb_rob_id_o   = wb_rob_id_q;
  assign wb_link_o     = wb_link_q;
  assign wb_link_we_o  = wb_link_we_q;
  assign wb_mispred_o  = wb_mispred_q;
  assign upd_pc_o      = mem_q[rd_q].pc;
  assign upd_taken_o   = mem_q[rd_q].taken;
  assign upd_target_o  = mem_q[rd_q].target;
  assign upd_type_o    = mem_q[rd_q].typ;

`ifdef WIRED_BR_PERF_EN
  logic [31:0] perf_branch_q, perf_mispred_q;

  // Event counters, cleared only by reset, wrapping naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_branch_q  <= '0;
      perf_mispred_q <= '0;
    end else begin
      if (push)           perf_branch_q  <= perf_branch_q + 32'd1;
      if (push & mispred) perf_mispred_q <= perf_mispred_q + 32'd1;
    end
  end

  assign perf_branch_o  = perf_branch_q;
  assign perf_mispred_o = perf_mispred_q;
`endif

endmodule

// File: tb/tb_wired_branch_resolve.sv
// Directed bench for wired_branch_resolve: a table of single-branch vectors
// followed by hand-written shadow, backpressure, stall/flush and reset sequences.
module tb_wired_branch_resolve;
  localparam int ROB_W = 6;

  logic clk = 1'b0, rst_n = 1'b0;
  logic in_valid, in_ready, taken, pred_taken, flush, wb_ready, upd_ready;
  logic [31:0] pc, target, pred_target;
  logic [ROB_W-1:0] rob_id;
  logic [1:0] ttype;
  logic redir_valid, wb_valid, wb_link_we, wb_mispred, upd_valid, upd_taken;
  logic [31:0] redir_pc, wb_link, upd_pc, upd_target;
  logic [ROB_W-1:0] wb_rob_id;
  logic [1:0] upd_type;
`ifdef WIRED_BR_PERF_EN
  logic [31:0] perf_branch, perf_mispred;
`endif

  wired_branch_resolve #(.ROB_W(ROB_W), .UPD_DEPTH(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid_i(in_valid), .in_ready_o(in_ready),
    .pc_i(pc), .rob_id_i(rob_id), .target_type_i(ttype),
    .taken_i(taken), .target_i(target),
    .pred_taken_i(pred_taken), .pred_target_i(pred_target),
    .flush_i(flush),
    .redir_valid_o(redir_valid), .redir_pc_o(redir_pc),
    .wb_valid_o(wb_valid), .wb_ready_i(wb_ready),
    .wb_rob_id_o(wb_rob_id), .wb_link_o(wb_link),
    .wb_link_we_o(wb_link_we), .wb_mispred_o(wb_mispred),
    .upd_valid_o(upd_valid), .upd_ready_i(upd_ready),
    .upd_pc_o(upd_pc), .upd_taken_o(upd_taken),
    .upd_target_o(upd_target), .upd_type_o(upd_type)
`ifdef WIRED_BR_PERF_EN
    , .perf_branch_o(perf_branch), .perf_mispred_o(perf_mispred)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [1:0]  ttype;
    logic        taken;
    logic [31:0] target;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        exp_mis;
    logic [31:0] exp_redir_pc;
    logic [31:0] exp_link;
    logic        exp_we;
  } vec_t;

  int nvec = 0;
  int nerr = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] p, input logic [1:0] t, input logic tk,
                       input logic [31:0] tg, input logic ptk, input logic [31:0] ptg,
                       input logic [ROB_W-1:0] id);
    in_valid = 1'b1; pc = p; ttype = t; taken = tk; target = tg;
    pred_taken = ptk; pred_target = ptg; rob_id = id;
  endtask

  vec_t v [7];

  initial begin
    v[0] = '{32'h1000, 2'd3, 1'b1, 32'h2000, 1'b1, 32'h2000, 1'b0, 32'h0,       32'h1004, 1'b0};
    v[1] = '{32'h1000, 2'd3, 1'b0, 32'h2000, 1'b1, 32'h2000, 1'b1, 32'h1004,    32'h1004, 1'b0};
    v[2] = '{32'h4000, 2'd1, 1'b1, 32'h3000, 1'b1, 32'h3004, 1'b1, 32'h3000,    32'h4004, 1'b1};
    v[3] = '{32'hFFFFFFFC, 2'd3, 1'b0, 32'h10, 1'b1, 32'h10,  1'b1, 32'h0,       32'h0,    1'b0};
    v[4] = '{32'h500,  2'd0, 1'b0, 32'h999,  1'b0, 32'h123,  1'b0, 32'h0,       32'h504,  1'b0};
    v[5] = '{32'h600,  2'd2, 1'b1, 32'h700,  1'b0, 32'h700,  1'b1, 32'h700,     32'h604,  1'b0};
    v[6] = '{32'h680,  2'd1, 1'b0, 32'h900,  1'b0, 32'h904,  1'b0, 32'h0,       32'h684,  1'b1};

    in_valid = 0; pc = 0; ttype = 0; taken = 0; target = 0; pred_taken = 0;
    pred_target = 0; rob_id = 0; flush = 0; wb_ready = 1; upd_ready = 1;

    // Reset state.
    #12;
    nvec++;
    chk("rst redir_valid", 32'(redir_valid), 32'd0);
    chk("rst redir_pc", redir_pc, 32'd0);
    chk("rst wb_valid", 32'(wb_valid), 32'd0);
    chk("rst upd_valid", 32'(upd_valid), 32'd0);
    chk("rst upd_pc", upd_pc, 32'd0);
    rst_n = 1'b1;
    tick();

    // Table: one branch each, checked the cycle after acceptance, then flushed.
    for (int i = 0; i < 7; i++) begin
      nvec++;
      drive(v[i].pc, v[i].ttype, v[i].taken, v[i].target, v[i].pred_taken, v[i].pred_target, ROB_W'(i + 1));
      #1;
      chk($sformatf("v%0d in_ready", i), 32'(in_ready), 32'd1);
      tick();
      in_valid = 0;
      chk($sformatf("v%0d wb_valid", i), 32'(wb_valid), 32'd1);
      chk($sformatf("v%0d wb_rob_id", i), 32'(wb_rob_id), 32'(i + 1));
      chk($sformatf("v%0d wb_mispred", i), 32'(wb_mispred), 32'(v[i].exp_mis));
      chk($sformatf("v%0d wb_link", i), wb_link, v[i].exp_link);
      chk($sformatf("v%0d wb_link_we", i), 32'(wb_link_we), 32'(v[i].exp_we));
      chk($sformatf("v%0d redir_valid", i), 32'(redir_valid), 32'(v[i].exp_mis));
      if (v[i].exp_mis) chk($sformatf("v%0d redir_pc", i), redir_pc, v[i].exp_redir_pc);
      chk($sformatf("v%0d upd_valid", i), 32'(upd_valid), 32'd1);
      chk($sformatf("v%0d upd_pc", i), upd_pc, v[i].pc);
      chk($sformatf("v%0d upd_taken", i), 32'(upd_taken), 32'(v[i].taken));
      chk($sformatf("v%0d upd_target", i), upd_target, v[i].target);
      chk($sformatf("v%0d upd_type", i), 32'(upd_type), 32'(v[i].ttype));
      tick();
      chk($sformatf("v%0d redir pulse end", i), 32'(redir_valid), 32'd0);
      chk($sformatf("v%0d wb drained", i), 32'(wb_valid), 32'd0);
      chk($sformatf("v%0d upd drained", i), 32'(upd_valid), 32'd0);
      flush = 1; tick(); flush = 0; tick();
    end

    // Shadow: wrong-path branch is taken in and vanishes, flush restores RUN.
    nvec++;
    drive(32'h1000, 2'd3, 1'b0, 32'h2000, 1'b1, 32'h2000, 6'd9);
    tick();
    chk("sh redir_valid", 32'(redir_valid), 32'd1);
    chk("sh redir_pc", redir_pc, 32'h1004);
    drive(32'h8000, 2'd1, 1'b1, 32'h9000, 1'b0, 32'h0, 6'd10);
    wb_ready = 0; upd_ready = 0;
    #1;
    chk("sh in_ready", 32'(in_ready), 32'd1);
    tick();
    in_valid = 0; wb_ready = 1; upd_ready = 1;
    chk("sh redir dropped", 32'(redir_valid), 32'd0);
    chk("sh wb holds first", 32'(wb_rob_id), 32'd9);
    chk("sh upd head", upd_pc, 32'h1000);
    tick();
    chk("sh wb none", 32'(wb_valid), 32'd0);
    chk("sh upd none", 32'(upd_valid), 32'd0);
    flush = 1; tick(); flush = 0;
    drive(32'hA000, 2'd3, 1'b1, 32'hB000, 1'b1, 32'hB000, 6'd11);
    tick();
    in_valid = 0;
    chk("sh run again wb", 32'(wb_valid), 32'd1);
    chk("sh run again id", 32'(wb_rob_id), 32'd11);
    tick(); tick();

    // Update FIFO backpressure, then in-order drain.
    nvec++;
    upd_ready = 0;
    drive(32'h100, 2'd3, 1'b0, 32'h0, 1'b0, 32'h0, 6'd1);
    tick();
    drive(32'h200, 2'd3, 1'b0, 32'h0, 1'b0, 32'h0, 6'd2);
    #1;
    chk("bp ready 2nd", 32'(in_ready), 32'd1);
    tick();
    drive(32'h300, 2'd3, 1'b0, 32'h0, 1'b0, 32'h0, 6'd3);
    #1;
    chk("bp ready full", 32'(in_ready), 32'd0);
    tick();
    chk("bp still blocked", 32'(in_ready), 32'd0);
    chk("bp head held", upd_pc, 32'h100);
    upd_ready = 1;
    #1;
    chk("bp ready on pop", 32'(in_ready), 32'd1);
    tick();
    in_valid = 0;
    chk("bp drain 2", upd_pc, 32'h200);
    tick();
    chk("bp drain 3", upd_pc, 32'h300);
    chk("bp drain 3 valid", 32'(upd_valid), 32'd1);
    tick();
    chk("bp drained", 32'(upd_valid), 32'd0);

    // wb stall for 3 cycles, flush during stall clears wb but keeps the FIFO.
    nvec++;
    wb_ready = 0; upd_ready = 0;
    drive(32'h800, 2'd1, 1'b0, 32'h0, 1'b0, 32'h0, 6'd21);
    tick();
    drive(32'h900, 2'd3, 1'b0, 32'h0, 1'b0, 32'h0, 6'd22);
    for (int c = 0; c < 3; c++) begin
      chk($sformatf("st%0d in_ready", c), 32'(in_ready), 32'd0);
      chk($sformatf("st%0d wb_valid", c), 32'(wb_valid), 32'd1);
      chk($sformatf("st%0d wb_rob_id", c), 32'(wb_rob_id), 32'd21);
      chk($sformatf("st%0d wb_link", c), wb_link, 32'h804);
      tick();
    end
    flush = 1;
    #1;
    chk("st flush in_ready", 32'(in_ready), 32'd0);
    tick();
    flush = 0; in_valid = 0;
    chk("st flush wb cleared", 32'(wb_valid), 32'd0);
    chk("st fifo kept", 32'(upd_valid), 32'd1);
    chk("st fifo head", upd_pc, 32'h800);
    upd_ready = 1; wb_ready = 1;
    tick();
    chk("st fifo single entry", 32'(upd_valid), 32'd0);

    // Reset during operation discards pending state.
    nvec++;
    upd_ready = 0;
    drive(32'hC00, 2'd3, 1'b1, 32'hD00, 1'b0, 32'h0, 6'd5);
    tick();
    in_valid = 0;
    chk("mr pre upd_valid", 32'(upd_valid), 32'd1);
    chk("mr pre redir", 32'(redir_valid), 32'd1);
    rst_n = 0;
    #1;
    chk("mr upd_valid", 32'(upd_valid), 32'd0);
    chk("mr wb_valid", 32'(wb_valid), 32'd0);
    chk("mr redir", 32'(redir_valid), 32'd0);
    chk("mr upd_pc", upd_pc, 32'd0);
    tick();
    rst_n = 1; upd_ready = 1;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  // Watchdog so the run always ends.
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
endmodule
